memdump_uart_tx: RTL and testbench

Read-side counterpart of the button-driven digit memory: on a one-cycle start pulse (from the debounced button block), walks every entry of the 8x8 memory through a synchronous read port and transmits each byte as a UART frame. It sits between the memory array and the board's serial pin, so stored contents can be dumped to a host. The current address is exported so it can be shown on the address seven-seg digit.

---
 rtl/memdump_pkg.sv | 11 +
 rtl/memdump_uart_tx_byte.sv | 68 ++++++
 rtl/memdump_uart_tx.sv | 65 ++++++
 tb/tb_memdump_uart_tx.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/memdump_pkg.sv
// memdump_pkg: state encodings and baud-rate helpers for the memory dump UART.
package memdump_pkg;
  localparam logic [2:0] ST_IDLE = 3'd0, ST_FETCH = 3'd1, ST_LOAD = 3'd2, ST_SEND = 3'd3, ST_NEXT = 3'd4, ST_FIN = 3'd5;
  localparam logic [2:0] TX_IDLE = 3'd0, TX_START = 3'd1, TX_DATA = 3'd2, TX_PARITY = 3'd3, TX_STOP = 3'd4;
  function automatic int clks_per_bit(input int clk_freq, input int baud);
    return clk_freq / baud;
  endfunction
  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/memdump_uart_tx_byte.sv
// uart_tx_byte: byte serializer with valid/ready handshake; MEMDUMP_PARITY_EN adds an even parity bit.
module uart_tx_byte
  import memdump_pkg::*;
#(
  parameter int CLKS_PER_BIT = 10,
  parameter int DATA_W       = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              valid,
  input  logic [DATA_W-1:0] data,
  output logic              ready,
  output logic              tx,
  output logic              last
);
  localparam int CW = cnt_width(CLKS_PER_BIT);
  localparam int BW = cnt_width(DATA_W);
  logic [2:0]        state;
  logic [CW-1:0]     cnt;
  logic [BW-1:0]     bit_idx;
  logic [DATA_W-1:0] shift;
  logic              tick;
  assign tick  = cnt == CW'(CLKS_PER_BIT - 1);
  assign ready = state == TX_IDLE;
  assign last  = state == TX_STOP && tick;
`ifdef MEMDUMP_PARITY_EN
  logic par;
  assign tx = (state == TX_START) ? 1'b0 : (state == TX_DATA) ? shift[0] : (state == TX_PARITY) ? par : 1'b1;
  always_ff @(posedge clk or negedge reset)
    if (!reset) par <= 1'b0;
    else if (state == TX_IDLE && valid) par <= ^data;
`else
  assign tx = (state == TX_START) ? 1'b0 : (state == TX_DATA) ? shift[0] : 1'b1;
`endif
  // every transition happens on tick or out of idle, so the counter restarts at 0 on each state entry
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= TX_IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      shift   <= '0;
    end else begin
      cnt <= (state == TX_IDLE || tick) ? '0 : cnt + 1'b1;
      case (state)
        TX_IDLE: if (valid) begin
          shift <= data;
          state <= TX_START;
        end
        TX_START: if (tick) state <= TX_DATA;
        TX_DATA: if (tick) begin
          shift   <= shift >> 1;
          bit_idx <= bit_idx + 1'b1;
          if (bit_idx == BW'(DATA_W - 1)) begin
            bit_idx <= '0;
`ifdef MEMDUMP_PARITY_EN
            state <= TX_PARITY;
`else
            state <= TX_STOP;
`endif
          end
        end
        TX_PARITY: if (tick) state <= TX_STOP;
        TX_STOP: if (tick) state <= TX_IDLE;
        default: state <= TX_IDLE;
      endcase
    end
  end
endmodule

// File: rtl/memdump_uart_tx.sv
// memdump_uart_tx: walks the whole memory on a start pulse and sends each word over UART.
// Build with MEMDUMP_PARITY_EN for 8E1 frames; default is 8N1.
module memdump_uart_tx
  import memdump_pkg::*;
#(
  parameter int CLK_FREQ = 50000000,
  parameter int BAUD     = 9600,
  parameter int ADDR_W   = 3,
  parameter int DATA_W   = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic [ADDR_W-1:0] rd_addr,
  output logic              rd_en,
  input  logic [DATA_W-1:0] rd_data,
  output logic              tx,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] cur_addr
);
  localparam int CPB = clks_per_bit(CLK_FREQ, BAUD);
  logic [2:0]        state;
  logic [ADDR_W-1:0] addr;
  logic              tx_ready, tx_last;
  assign rd_en   = state == ST_FETCH;
  assign rd_addr = addr;
  assign busy    = state != ST_IDLE && state != ST_FIN;
  assign done    = state == ST_FIN;
  uart_tx_byte #(.CLKS_PER_BIT(CPB), .DATA_W(DATA_W)) u_ser (
    .clk   (clk),
    .reset (reset),
    .valid (state == ST_LOAD),
    .data  (rd_data),
    .ready (tx_ready),
    .tx    (tx),
    .last  (tx_last)
  );
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= ST_IDLE;
      addr     <= '0;
      cur_addr <= '0;
    end else begin
      case (state)
        ST_IDLE: if (start) begin
          addr  <= '0;
          state <= ST_FETCH;
        end
        ST_FETCH: state <= ST_LOAD;
        ST_LOAD: if (tx_ready) begin
          cur_addr <= addr;
          state    <= ST_SEND;
        end
        ST_SEND: if (tx_last) state <= ST_NEXT;
        ST_NEXT: if (addr == '1) state <= ST_FIN;
        else begin
          addr  <= addr + 1'b1;
          state <= ST_FETCH;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_memdump_uart_tx.sv
// tb_memdump_uart_tx: scoreboard bench decoding UART frames from memdump_uart_tx.
module tb_memdump_uart_tx;
`ifdef MEMDUMP_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif
  localparam int GAP    = NBITS * 10 + 3;
  localparam int STOP_T = (NBITS - 1) * 10 + 5;
  typedef struct {logic [7:0] d; logic [2:0] a;} exp_t;
  logic clk = 0, reset = 0, start = 0;
  logic [2:0] rd_addr, cur_addr;
  logic rd_en, tx, busy, done;
  logic [7:0] rd_data = 0;
  logic [7:0] mem [8];
  exp_t sb[$];
  int n_cmp = 0, n_bad = 0;
  int cyc = 0, last_start = -1, frames = 0, done_cnt = 0, rx_t = 0;
  logic rx_on = 0, prev_busy = 0, rx_par = 0;
  logic [7:0] rx_byte;

  memdump_uart_tx #(.CLK_FREQ(10), .BAUD(1), .ADDR_W(3), .DATA_W(8)) dut (
    .clk(clk), .reset(reset), .start(start), .rd_addr(rd_addr), .rd_en(rd_en),
    .rd_data(rd_data), .tx(tx), .busy(busy), .done(done), .cur_addr(cur_addr)
  );

  always #5 clk = ~clk;
  always @(posedge clk) if (rd_en) rd_data <= mem[rd_addr];

  always @(negedge clk) begin
    exp_t e;
    cyc++;
    if (done === 1'b1) begin
      done_cnt++;
      n_cmp++;
      if (busy !== 1'b0 || prev_busy !== 1'b1) begin
        n_bad++;
        $display("FAIL done_busy: busy=%b prev_busy=%b, required busy=0 prev_busy=1", busy, prev_busy);
      end
    end
    prev_busy = busy;
    if (!reset) rx_on = 0;
    else if (!rx_on) begin
      if (tx === 1'b0) begin
        rx_on = 1;
        rx_t = 0;
        frames++;
        if (last_start >= 0) begin
          n_cmp++;
          if (cyc - last_start != GAP) begin
            n_bad++;
            $display("FAIL frame_gap: %0d cycles between starts, required %0d", cyc - last_start, GAP);
          end
        end
        last_start = cyc;
      end
    end else begin
      rx_t++;
      if (rx_t == 5) begin
        n_cmp++;
        if (tx !== 1'b0) begin
          n_bad++;
          $display("FAIL start_bit: tx=%b, required 0", tx);
        end
      end else if (rx_t >= 15 && rx_t < 95 && (rx_t - 15) % 10 == 0) rx_byte[(rx_t - 15) / 10] = tx;
      else if (rx_t == 95 && NBITS == 11) rx_par = tx;
      else if (rx_t == STOP_T) begin
        rx_on = 0;
        n_cmp++;
        if (sb.size() == 0) begin
          n_bad++;
          $display("FAIL frame_unexpected: got byte %h, required no frame", rx_byte);
        end else begin
          e = sb.pop_front();
          if (tx !== 1'b1 || rx_byte !== e.d || cur_addr !== e.a || (NBITS == 11 && rx_par !== ^e.d)) begin
            n_bad++;
            $display("FAIL frame: stop=%b byte=%h addr=%0d par=%b, required stop=1 byte=%h addr=%0d par=%b",
                     tx, rx_byte, cur_addr, rx_par, e.d, e.a, ^e.d);
          end
        end
      end
    end
  end

  task automatic pulse_start();
    @(posedge clk); #1 start = 1;
    @(posedge clk); #1 start = 0;
  endtask

  task automatic push_dump();
    for (int i = 0; i < 8; i++) sb.push_back('{d: mem[i], a: 3'(i)});
  endtask

  task automatic start_dump();
    last_start = -1;
    frames = 0;
    done_cnt = 0;
    push_dump();
    pulse_start();
  endtask

  task automatic wait_done(input string tag);
    logic got = 0;
    for (int k = 0; k < 1200 && !got; k++) begin
      @(negedge clk);
      if (done === 1'b1) got = 1;
    end
    n_cmp++;
    if (!got) begin
      n_bad++;
      $display("FAIL %s_done_timeout: done=0, required a done pulse", tag);
    end
  endtask

  task automatic wait_frames(input int n, input int t);
    logic got = 0;
    for (int k = 0; k < 1200 && !got; k++) begin
      @(negedge clk);
      if (frames >= n && rx_on && rx_t >= t) got = 1;
    end
    n_cmp++;
    if (!got) begin
      n_bad++;
      $display("FAIL frame_wait_timeout: frames=%0d, required %0d", frames, n);
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    n_cmp++;
    if ({tx, busy, done, rd_en, rd_addr, cur_addr} !== {4'b1000, 3'd0, 3'd0}) begin
      n_bad++;
      $display("FAIL reset_state: tx=%b busy=%b done=%b rd_en=%b rd_addr=%0d cur_addr=%0d, required 1 0 0 0 0 0",
               tx, busy, done, rd_en, rd_addr, cur_addr);
    end
    #2 reset = 1;
  endtask

  task automatic test_dump();
    for (int i = 0; i < 8; i++) mem[i] = 8'(i * 8'h11);
    start_dump();
    @(negedge clk);
    n_cmp++;
    if ({busy, rd_en, rd_addr} !== {2'b11, 3'd0}) begin
      n_bad++;
      $display("FAIL dump_fetch: busy=%b rd_en=%b rd_addr=%0d, required 1 1 0", busy, rd_en, rd_addr);
    end
    wait_done("dump");
    repeat (3) @(negedge clk);
    n_cmp++;
    if (done_cnt != 1 || sb.size() != 0 || busy !== 1'b0 || tx !== 1'b1) begin
      n_bad++;
      $display("FAIL dump_end: done_cnt=%0d left=%0d busy=%b tx=%b, required 1 0 0 1", done_cnt, sb.size(), busy, tx);
    end
  endtask

  task automatic test_back_to_back();
    logic bad = 0;
    mem[3] = 8'hA5;
    start_dump();
    wait_frames(2, 3);
    pulse_start();
    wait_done("b2b");
    start = 1;
    @(posedge clk); #1 start = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (busy !== 1'b0 || tx !== 1'b1) bad = 1;
    end
    n_cmp++;
    if (bad || done_cnt != 1 || sb.size() != 0) begin
      n_bad++;
      $display("FAIL b2b_ignored: bad=%b done_cnt=%0d left=%0d, required 0 1 0", bad, done_cnt, sb.size());
    end
  endtask

  task automatic test_restart();
    start_dump();
    wait_done("restart_first");
    last_start = -1;
    push_dump();
    @(posedge clk); #1 start = 1;
    @(posedge clk); #1 start = 0;
    @(negedge clk);
    n_cmp++;
    if ({busy, rd_en, rd_addr} !== {2'b11, 3'd0}) begin
      n_bad++;
      $display("FAIL restart_fetch: busy=%b rd_en=%b rd_addr=%0d, required 1 1 0", busy, rd_en, rd_addr);
    end
    wait_done("restart_second");
    repeat (2) @(negedge clk);
    n_cmp++;
    if (done_cnt != 2 || sb.size() != 0) begin
      n_bad++;
      $display("FAIL restart_end: done_cnt=%0d left=%0d, required 2 0", done_cnt, sb.size());
    end
  endtask

  task automatic test_reset_mid();
    logic bad = 0;
    start_dump();
    wait_frames(5, 33);
    #2 reset = 0;
    #1;
    n_cmp++;
    if ({tx, busy} !== 2'b10) begin
      n_bad++;
      $display("FAIL reset_async: tx=%b busy=%b, required 1 0", tx, busy);
    end
    n_cmp++;
    if (sb.size() != 4) begin
      n_bad++;
      $display("FAIL reset_pending: %0d frames left, required 4", sb.size());
    end
    sb.delete();
    repeat (2) @(negedge clk);
    #2 reset = 1;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (tx !== 1'b1 || busy !== 1'b0 || rd_en !== 1'b0) bad = 1;
    end
    n_cmp++;
    if (bad) begin
      n_bad++;
      $display("FAIL reset_quiet: activity after reset release, required idle");
    end
    start_dump();
    wait_done("reset_redump");
    repeat (2) @(negedge clk);
    n_cmp++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL reset_redump: %0d frames left, required 0", sb.size());
    end
  endtask

  task automatic test_rewrite();
    for (int i = 0; i < 8; i++) mem[i] = 8'(i * 8'h11);
    start_dump();
    sb[6].d = 8'h3C;
    wait_frames(2, 20);
    mem[6] = 8'h3C;
    mem[0] = 8'hEE;
    wait_done("rewrite");
    repeat (2) @(negedge clk);
    n_cmp++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL rewrite_end: %0d frames left, required 0", sb.size());
    end
  endtask

`ifdef MEMDUMP_PARITY_EN
  task automatic test_parity();
    mem[0] = 8'h07;
    mem[1] = 8'h03;
    start_dump();
    wait_done("parity");
    repeat (2) @(negedge clk);
    n_cmp++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL parity_end: %0d frames left, required 0", sb.size());
    end
  endtask
`endif

  initial begin
    for (int i = 0; i < 8; i++) mem[i] = 8'(i * 8'h11);
    test_reset();
    test_dump();
    test_back_to_back();
    test_restart();
    test_reset_mid();
    test_rewrite();
`ifdef MEMDUMP_PARITY_EN
    test_parity();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
